// File: rtl/branch_n_reg_pkg.sv
// Shared helpers for handshake components: index-width derivation and flat-vector lane slicing.
package branch_n_reg_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Low bit of lane `lane` in a flat vector of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/join_type.sv
// N-input join: output valid when every input is valid; each input is ready when the rest are valid.
module join_type #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0] ins_valid,
    output logic [SIZE-1:0] ins_ready,
    output logic            outs_valid,
    input  logic            outs_ready
);
    always_comb begin
        outs_valid = &ins_valid;
        for (int i = 0; i < SIZE; i++)
            ins_ready[i] = outs_ready & (&(ins_valid | (SIZE'(1) << i)));
    end
endmodule

// File: rtl/oehb_slot.sv
// One-slot output register: accepts while empty or draining, so throughput stays at one token per cycle.
module oehb_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_keep,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             full,
    output logic [WIDTH-1:0] q,
    output logic             slot_ready,
    output logic             fire
);
    logic drain;

    assign drain      = full & out_ready;
    assign slot_ready = ~full | drain;
    assign fire       = in_valid & slot_ready;

    // A consumed-but-dropped token (in_keep=0) leaves the slot alone except for a concurrent drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (fire && in_keep) begin
            full <= 1'b1;
            q    <= in_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/branch_n_reg.sv
// N-way registered data branch: joins data and index, then steers the pair to one output channel.
module branch_n_reg
    import branch_n_reg_pkg::*;
#(
    parameter int NUM_OUTS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = clog2(NUM_OUTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          data,
    input  logic                           data_valid,
    output logic                           data_ready,
    input  logic [SEL_WIDTH-1:0]           index,
    input  logic                           index_valid,
    output logic                           index_ready,
    output logic [NUM_OUTS*DATA_WIDTH-1:0] outs,
    output logic [NUM_OUTS-1:0]            outs_valid,
    input  logic [NUM_OUTS-1:0]            outs_ready,
    output logic                           err_oob
);
    logic                          join_valid, slot_ready, fire, full_q, in_range, sel_ready, err_q;
    logic [DATA_WIDTH-1:0]         data_q;
    logic [SEL_WIDTH-1:0]          sel_q;
    logic [NUM_OUTS-1:0]           sel_hit;

    join_type #(.SIZE(2)) u_join (
        .ins_valid  ({index_valid, data_valid}),
        .ins_ready  ({index_ready, data_ready}),
        .outs_valid (join_valid),
        .outs_ready (slot_ready)
    );

    assign in_range = {1'b0, index} < (SEL_WIDTH+1)'(NUM_OUTS);

    oehb_slot #(.WIDTH(DATA_WIDTH + SEL_WIDTH)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (join_valid),
        .in_keep    (in_range),
        .in_data    ({index, data}),
        .out_ready  (sel_ready),
        .full       (full_q),
        .q          ({sel_q, data_q}),
        .slot_ready (slot_ready),
        .fire       (fire)
    );

    // sel_q only ever holds an in-range index, so the one-hot decode replaces a variable index into outs_ready.
    always_comb begin
        for (int i = 0; i < NUM_OUTS; i++)
            sel_hit[i] = (sel_q == SEL_WIDTH'(i));
    end

    assign sel_ready  = |(sel_hit & outs_ready);
    assign outs_valid = full_q ? sel_hit : '0;

    for (genvar i = 0; i < NUM_OUTS; i++) begin : g_lane
        assign outs[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  err_q <= 1'b0;
        else if (fire && !in_range) err_q <= 1'b1;
    end

    assign err_oob = err_q;
endmodule

// File: tb/tb_branch_n_reg.sv
// Bench for branch_n_reg: 4-way instance for steering/streaming/back-pressure, 3-way for out-of-range.
module tb_branch_n_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]  d4_data;
    logic         d4_dv, d4_dr, d4_iv, d4_ir, d4_err;
    logic [1:0]   d4_idx;
    logic [127:0] d4_outs;
    logic [3:0]   d4_ov, d4_ordy;

    logic [7:0]   d3_data;
    logic         d3_dv, d3_dr, d3_iv, d3_ir, d3_err;
    logic [1:0]   d3_idx;
    logic [23:0]  d3_outs;
    logic [2:0]   d3_ov, d3_ordy;

    branch_n_reg #(.NUM_OUTS(4), .DATA_WIDTH(32)) dut4 (
        .clk(clk), .rst(rst), .data(d4_data), .data_valid(d4_dv), .data_ready(d4_dr),
        .index(d4_idx), .index_valid(d4_iv), .index_ready(d4_ir), .outs(d4_outs),
        .outs_valid(d4_ov), .outs_ready(d4_ordy), .err_oob(d4_err)
    );

    branch_n_reg #(.NUM_OUTS(3), .DATA_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .data(d3_data), .data_valid(d3_dv), .data_ready(d3_dr),
        .index(d3_idx), .index_valid(d3_iv), .index_ready(d3_ir), .outs(d3_outs),
        .outs_valid(d3_ov), .outs_ready(d3_ordy), .err_oob(d3_err)
    );

    typedef struct { logic [31:0] data; logic [1:0] sel; } tok_t;
    typedef struct {
        logic dv, iv; logic [1:0] idx; logic [31:0] data; logic [3:0] ordy;
        logic [3:0] eov; logic edr, eir;
    } vec_t;

    tok_t sb[$];
    vec_t tbl[15];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic dv, input logic iv, input logic [1:0] idx,
                          input logic [31:0] dat, input logic [3:0] ordy);
        d4_dv = dv; d4_iv = iv; d4_idx = idx; d4_data = dat; d4_ordy = ordy;
    endtask

    // Scoreboard front is the token the slot should hold; checks readies/valids, pops on drain, pushes on fire.
    task automatic tick4();
        logic [3:0] eov;
        logic       drn, sr, fire;
        #1;
        eov  = (sb.size() != 0) ? (4'(1) << sb[0].sel) : 4'b0;
        drn  = (sb.size() != 0) && d4_ordy[sb[0].sel];
        sr   = (sb.size() == 0) || drn;
        fire = d4_dv && d4_iv && sr;
        chk("outs_valid", 128'(d4_ov), 128'(eov));
        chk("data_ready", 128'(d4_dr), 128'(d4_iv & sr));
        chk("index_ready", 128'(d4_ir), 128'(d4_dv & sr));
        if (drn) begin
            chk("outs_lane", 128'(d4_outs[sb[0].sel*32 +: 32]), 128'(sb[0].data));
            void'(sb.pop_front());
        end
        if (fire) sb.push_back('{d4_data, d4_idx});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 4'h0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,        4'hF, 4'h4, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 32'h0,        4'hF, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2'd0, 32'hA0,       4'hF, 4'h0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 2'd1, 32'hA1,       4'hF, 4'h1, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 2'd2, 32'hA2,       4'hF, 4'h2, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 2'd3, 32'hA3,       4'hF, 4'h4, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 2'd0, 32'hA4,       4'hF, 4'h8, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,        4'hF, 4'h1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'd1, 32'h77,       4'hF, 4'h0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 2'd1, 32'h77,       4'hF, 4'h0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 2'd1, 32'h77,       4'hF, 4'h0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 2'd1, 32'h77,       4'hF, 4'h0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 32'h0,        4'hF, 4'h2, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 32'h0,        4'hF, 4'h0, 1'b0, 1'b0};

        rst = 1'b0;
        drive4(1'b1, 1'b1, 2'd0, 32'h1234, 4'hF);
        d3_dv = 1'b0; d3_iv = 1'b0; d3_idx = 2'd0; d3_data = 8'h0; d3_ordy = 3'b111;

        // Reset held with a token offered: nothing may be stored or shown.
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_outs_valid", 128'(d4_ov), 128'h0);
            chk("rst_err", 128'(d4_err), 128'h0);
            chk("rst_outs", d4_outs, 128'h0);
            chk("rst_data_ready", 128'(d4_dr), 128'h1);
            chk("rst_index_ready", 128'(d4_ir), 128'h1);
        end
        @(negedge clk);
        rst = 1'b1;
        tick4();
        drive4(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        #1 chk("release_accept", 128'(d4_ov), 128'h1);
        tick4();

        foreach (tbl[i]) begin
            drive4(tbl[i].dv, tbl[i].iv, tbl[i].idx, tbl[i].data, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d_ov", i), 128'(d4_ov), 128'(tbl[i].eov));
            chk($sformatf("tbl%0d_dr", i), 128'(d4_dr), 128'(tbl[i].edr));
            chk($sformatf("tbl%0d_ir", i), 128'(d4_ir), 128'(tbl[i].eir));
            tick4();
        end

        // Back-pressure on channel 1; the other channels' readies must not matter.
        drive4(1'b1, 1'b1, 2'd1, 32'h11, 4'b1101);
        tick4();
        drive4(1'b1, 1'b1, 2'd3, 32'h22, 4'b1101);
        repeat (5) begin
            #1;
            chk("bp_ov", 128'(d4_ov), 128'h2);
            chk("bp_lane1", 128'(d4_outs[63:32]), 128'h11);
            chk("bp_dr", 128'(d4_dr), 128'h0);
            chk("bp_ir", 128'(d4_ir), 128'h0);
            tick4();
        end
        d4_ordy = 4'hF;
        #1 chk("bp_release_dr", 128'(d4_dr), 128'h1);
        tick4();
        drive4(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        #1 chk("bp_second_ov", 128'(d4_ov), 128'h8);
        tick4();
        tick4();

        // Out-of-range index on the 3-way instance.
        d3_dv = 1'b1; d3_iv = 1'b1; d3_idx = 2'd3; d3_data = 8'h55;
        #1;
        chk("oob_dr", 128'(d3_dr), 128'h1);
        chk("oob_ir", 128'(d3_ir), 128'h1);
        chk("oob_err_pre", 128'(d3_err), 128'h0);
        @(posedge clk); @(negedge clk);
        d3_dv = 1'b0; d3_iv = 1'b0;
        repeat (3) begin
            #1;
            chk("oob_ov", 128'(d3_ov), 128'h0);
            chk("oob_err", 128'(d3_err), 128'h1);
            @(posedge clk); @(negedge clk);
        end
        d3_dv = 1'b1; d3_iv = 1'b1; d3_idx = 2'd2; d3_data = 8'h66;
        @(posedge clk); @(negedge clk);
        d3_dv = 1'b0; d3_iv = 1'b0;
        #1;
        chk("oob_after_ov", 128'(d3_ov), 128'h4);
        chk("oob_after_lane2", 128'(d3_outs[23:16]), 128'h66);
        chk("oob_err_sticky", 128'(d3_err), 128'h1);
        @(posedge clk); @(negedge clk);

        // Reset while holding a token: discarded without handshake, error flag cleared.
        drive4(1'b1, 1'b1, 2'd2, 32'h99, 4'h0);
        tick4();
        drive4(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        #1 chk("midrst_held", 128'(d4_ov), 128'h4);
        rst = 1'b0;
        #1;
        chk("midrst_ov", 128'(d4_ov), 128'h0);
        chk("midrst_outs", d4_outs, 128'h0);
        chk("midrst_err3", 128'(d3_err), 128'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        d4_ordy = 4'hF;
        tick4();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
